// File: rtl/dma_pkg.sv
// Shared definitions for the single-channel DMA copy engine: register map,
// control/status bit positions and the transfer state machine encoding.
package dma_pkg;

    // Register word index, i.e. device_addr_i[4:2] of the byte offset.
    localparam logic [2:0] REG_SRC    = 3'd0;  // byte offset 0x00
    localparam logic [2:0] REG_DST    = 3'd1;  // byte offset 0x04
    localparam logic [2:0] REG_LEN    = 3'd2;  // byte offset 0x08
    localparam logic [2:0] REG_CTRL   = 3'd3;  // byte offset 0x0C
    localparam logic [2:0] REG_STATUS = 3'd4;  // byte offset 0x10

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;
    localparam int STATUS_ERR_BIT  = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4
    } dma_state_e;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/dma_regs.sv
// Register window of the DMA engine: decode, write-1-to-clear status bits,
// START pulse generation, device response and the registered interrupt.
module dma_regs
    import dma_pkg::*;
#(
    parameter int LenWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                device_req_i,
    input  logic [31:0]         device_addr_i,
    input  logic                device_we_i,
    input  logic [3:0]          device_be_i,
    input  logic [31:0]         device_wdata_i,
    output logic                device_rvalid_o,
    output logic [31:0]         device_rdata_o,
    input  logic                busy,
    input  logic                done_set,
    input  logic                err_set,
    output logic                start,
    output logic [31:0]         src,
    output logic [31:0]         dst,
    output logic [LenWidth-1:0] len,
    output logic                irq_o
);

    logic [31:0]         src_reg;
    logic [31:0]         dst_reg;
    logic [LenWidth-1:0] len_reg;
    logic                irq_en_reg;
    logic                done_reg;
    logic                err_reg;
    logic                rvalid_reg;
    logic [31:0]         rdata_reg;
    logic                irq_reg;

    logic [2:0]  reg_idx;
    logic        wr_en;
    logic        cfg_wr_en;
    logic        status_wr;
    logic [31:0] rd_value;
    logic        unused_addr_bits;

    assign reg_idx          = device_addr_i[4:2];
    assign unused_addr_bits = ^{device_addr_i[31:5], device_addr_i[1:0]};
    // Any byte enable writes the whole register.
    assign wr_en     = device_req_i & device_we_i & (|device_be_i);
    // Transfer parameters are frozen while a copy is in flight.
    assign cfg_wr_en = wr_en & ~busy;
    assign status_wr = wr_en & (reg_idx == REG_STATUS);
    assign start     = cfg_wr_en & (reg_idx == REG_CTRL) & device_wdata_i[CTRL_START_BIT];

    assign src = src_reg;
    assign dst = dst_reg;
    assign len = len_reg;

    // Program the transfer parameters and the interrupt enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_reg    <= '0;
            dst_reg    <= '0;
            len_reg    <= '0;
            irq_en_reg <= 1'b0;
        end else begin
            if (cfg_wr_en && reg_idx == REG_SRC) src_reg <= word_align(device_wdata_i);
            if (cfg_wr_en && reg_idx == REG_DST) dst_reg <= word_align(device_wdata_i);
            if (cfg_wr_en && reg_idx == REG_LEN) len_reg <= device_wdata_i[LenWidth-1:0];
            if (wr_en && reg_idx == REG_CTRL)    irq_en_reg <= device_wdata_i[CTRL_IRQ_EN_BIT];
        end
    end

    // DONE/ERR: engine set beats software clear; START restarts both, and a
    // zero-length START completes immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            if (done_set) begin
                done_reg <= 1'b1;
            end else if (start) begin
                done_reg <= (len_reg == '0);
            end else if (status_wr && device_wdata_i[STATUS_DONE_BIT]) begin
                done_reg <= 1'b0;
            end

            if (err_set) begin
                err_reg <= 1'b1;
            end else if (start) begin
                err_reg <= 1'b0;
            end else if (status_wr && device_wdata_i[STATUS_ERR_BIT]) begin
                err_reg <= 1'b0;
            end
        end
    end

    // Read data selection for the addressed register.
    always_comb begin
        rd_value = '0;
        case (reg_idx)
            REG_SRC:    rd_value = src_reg;
            REG_DST:    rd_value = dst_reg;
            REG_LEN:    rd_value = 32'(len_reg);
            REG_CTRL:   rd_value[CTRL_IRQ_EN_BIT] = irq_en_reg;
            REG_STATUS: begin
                rd_value[STATUS_BUSY_BIT] = busy;
                rd_value[STATUS_DONE_BIT] = done_reg;
                rd_value[STATUS_ERR_BIT]  = err_reg;
            end
            default:    rd_value = '0;
        endcase
    end

    // One-cycle device response; read data is zero outside read responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= device_req_i;
            rdata_reg  <= (device_req_i && !device_we_i) ? rd_value : '0;
        end
    end

    // Level interrupt, registered from the sticky status bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= irq_en_reg & (done_reg | err_reg);
        end
    end

    assign device_rvalid_o = rvalid_reg;
    assign device_rdata_o  = rdata_reg;
    assign irq_o           = irq_reg;

endmodule

// File: rtl/dma_host.sv
// Single-channel memory-to-memory copy engine. Reads one word, writes it,
// advances both addresses and repeats until the word count is exhausted or
// the bus reports an error. Only one bus transaction is ever outstanding.
module dma_host
    import dma_pkg::*;
#(
    parameter int LenWidth = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    output logic        host_req_o,
    input  logic        host_gnt_i,
    output logic [31:0] host_addr_o,
    output logic        host_we_o,
    output logic [3:0]  host_be_o,
    output logic [31:0] host_wdata_o,
    input  logic        host_rvalid_i,
    input  logic [31:0] host_rdata_i,
    input  logic        host_err_i,
    output logic        irq_o
);

    dma_state_e          state_reg;
    dma_state_e          state_next;
    logic [31:0]         work_src_reg;
    logic [31:0]         work_dst_reg;
    logic [LenWidth-1:0] count_reg;
    logic [31:0]         data_buf_reg;

    logic                busy;
    logic                start;
    logic                done_set;
    logic                err_set;
    logic                capture;
    logic                advance;
    logic [31:0]         prog_src;
    logic [31:0]         prog_dst;
    logic [LenWidth-1:0] prog_len;

    assign busy = (state_reg != ST_IDLE);

    dma_regs #(
        .LenWidth (LenWidth)
    ) u_regs (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .device_req_i    (device_req_i),
        .device_addr_i   (device_addr_i),
        .device_we_i     (device_we_i),
        .device_be_i     (device_be_i),
        .device_wdata_i  (device_wdata_i),
        .device_rvalid_o (device_rvalid_o),
        .device_rdata_o  (device_rdata_o),
        .busy            (busy),
        .done_set        (done_set),
        .err_set         (err_set),
        .start           (start),
        .src             (prog_src),
        .dst             (prog_dst),
        .len             (prog_len),
        .irq_o           (irq_o)
    );

    // Transfer state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and bus outputs; request fields depend only on state and
    // working registers, so they hold steady until the grant arrives.
    always_comb begin
        state_next   = state_reg;
        done_set     = 1'b0;
        err_set      = 1'b0;
        capture      = 1'b0;
        advance      = 1'b0;
        host_req_o   = 1'b0;
        host_we_o    = 1'b0;
        host_addr_o  = '0;
        host_be_o    = '0;
        host_wdata_o = '0;
        case (state_reg)
            ST_IDLE: begin
                if (start && prog_len != '0) state_next = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                host_req_o  = 1'b1;
                host_addr_o = work_src_reg;
                host_be_o   = 4'hF;
                if (host_gnt_i) state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (host_rvalid_i) begin
                    if (host_err_i) begin
                        err_set    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        capture    = 1'b1;
                        state_next = ST_WR_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                host_req_o   = 1'b1;
                host_we_o    = 1'b1;
                host_addr_o  = work_dst_reg;
                host_be_o    = 4'hF;
                host_wdata_o = data_buf_reg;
                if (host_gnt_i) state_next = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (host_rvalid_i) begin
                    if (host_err_i) begin
                        err_set    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        advance = 1'b1;
                        if (count_reg == LenWidth'(1)) begin
                            done_set   = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            state_next = ST_RD_REQ;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Working copy of the transfer parameters and the single-word buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            work_src_reg <= '0;
            work_dst_reg <= '0;
            count_reg    <= '0;
            data_buf_reg <= '0;
        end else begin
            if (start) begin
                work_src_reg <= prog_src;
                work_dst_reg <= prog_dst;
                count_reg    <= prog_len;
            end else if (advance) begin
                work_src_reg <= work_src_reg + 32'd4;
                work_dst_reg <= work_dst_reg + 32'd4;
                count_reg    <= count_reg - LenWidth'(1);
            end
            if (capture) data_buf_reg <= host_rdata_i;
        end
    end

endmodule
